// File: rtl/comb_gates_aoi21_debounce_if.sv
// comb_gates_aoi21_debounce_if: AOI21 inputs, clear, and debounced level/edge/count outputs
interface comb_gates_aoi21_debounce_if #(parameter int CNT_W = 8);
    logic             in0;
    logic             in1;
    logic             in2;
    logic             clear;
    logic             out;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] count;
    logic             sat;
    modport master (output in0, in1, in2, clear, input out, rise, fall, count, sat);
    modport slave  (input in0, in1, in2, clear, output out, rise, fall, count, sat);
endinterface

// File: rtl/comb_gates_aoi21_debounce.sv
// comb_gates_aoi21_debounce: registered AOI21 level, debounced, with edge pulses and saturating count
// AOI21_DEBOUNCE_BOTH_EDGES_EN counts fall pulses as well as rise pulses.
module comb_gates_aoi21_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic clk,
    input logic reset,
    comb_gates_aoi21_debounce_if.slave bus
);
`ifdef AOI21_DEBOUNCE_BOTH_EDGES_EN
    localparam logic both = 1'b1;
`else
    localparam logic both = 1'b0;
`endif
    localparam logic [7:0] last = 8'(STABLE_CYCLES - 1);
    typedef enum logic {STABLE, PENDING} state_t;
    state_t           state;
    logic             raw;
    logic             raw_q;
    logic             out_q;
    logic             rise_q;
    logic             fall_q;
    logic             sat_q;
    logic [7:0]       stab_cnt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nx;
    logic             accept;
    logic             inc;
    assign raw      = ~((bus.in0 & bus.in1) | bus.in2);
    assign accept   = (state == PENDING) && (raw_q != out_q) && (stab_cnt == last);
    assign inc      = accept && (raw_q || both);
    assign count_nx = count_q + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_q    <= 1'b0;
            out_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            state    <= STABLE;
            stab_cnt <= '0;
        end else begin
            raw_q  <= raw;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                STABLE: if (raw_q != out_q) begin
                    state    <= PENDING;
                    stab_cnt <= 8'd1;
                end
                PENDING: if (raw_q == out_q) begin
                    state    <= STABLE;
                    stab_cnt <= '0;
                end else if (accept) begin
                    out_q    <= raw_q;
                    rise_q   <= raw_q;
                    fall_q   <= ~raw_q;
                    state    <= STABLE;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + 8'd1;
                end
                default: state <= STABLE;
            endcase
            // clear wins over a coincident increment; sat tracks the all-ones count
            if (bus.clear) begin
                count_q <= '0;
                sat_q   <= 1'b0;
            end else if (inc && !sat_q) begin
                count_q <= count_nx;
                sat_q   <= &count_nx;
            end
        end
    end
    assign bus.out   = out_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.count = count_q;
    assign bus.sat   = sat_q;
endmodule

// File: tb/tb_comb_gates_aoi21_debounce.sv
// tb_comb_gates_aoi21_debounce: directed bench with an expected-count scoreboard
module tb_comb_gates_aoi21_debounce;
`ifdef AOI21_DEBOUNCE_BOTH_EDGES_EN
    localparam bit both = 1'b1;
`else
    localparam bit both = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    int   exp_q[$];
    comb_gates_aoi21_debounce_if #(.CNT_W(8)) bus ();
    comb_gates_aoi21_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic check_outs_zero(input string tag);
        check({tag, " out"}, int'(bus.out), 0);
        check({tag, " rise"}, int'(bus.rise), 0);
        check({tag, " fall"}, int'(bus.fall), 0);
        check({tag, " count"}, int'(bus.count), 0);
        check({tag, " sat"}, int'(bus.sat), 0);
    endtask
    // drive a new stable level, predict the count, then wait for the accepted edge
    task automatic ev(input bit lvl, input string tag);
        bit got = 1'b0;
        int e;
        if (lvl || both) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
        exp_q.push_back(exp_cnt);
        bus.in0 = 1'b0;
        bus.in1 = 1'b0;
        bus.in2 = ~lvl;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = bus.rise | bus.fall;
        end
        check({tag, " seen"}, int'(got), 1);
        e = exp_q.pop_front();
        check({tag, " rise"}, int'(bus.rise), int'(lvl));
        check({tag, " fall"}, int'(bus.fall), int'(!lvl));
        check({tag, " out"}, int'(bus.out), int'(lvl));
        check({tag, " count"}, int'(bus.count), e);
        check({tag, " sat"}, int'(bus.sat), int'(e == 255));
    endtask
    initial begin
        bus.in0 = 1'b1;
        bus.in1 = 1'b0;
        bus.in2 = 1'b1;
        bus.clear = 1'b0;
        repeat (3) step();
        #1 reset = 1'b0;
        #1 check_outs_zero("async_reset");
        bus.in0 = 1'b0;
        bus.in2 = 1'b0;
        step();
        check_outs_zero("reset_held");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("post_reset out", int'(bus.out), int'(i == 5));
            check("post_reset rise", int'(bus.rise), int'(i == 5));
            check("post_reset fall", int'(bus.fall), 0);
        end
        exp_cnt = 1;
        step();
        check("post_reset rise_drop", int'(bus.rise), 0);
        check("post_reset count", int'(bus.count), 1);
        bus.in2 = 1'b1;
        repeat (3) step();
        bus.in2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("glitch3 out", int'(bus.out), 1);
            check("glitch3 pulse", int'(bus.rise | bus.fall), 0);
            check("glitch3 count", int'(bus.count), 1);
            step();
        end
        bus.in2 = 1'b1;
        repeat (4) step();
        bus.in2 = 1'b0;
        step();
        if (both) exp_cnt++;
        check("glitch4 fall", int'(bus.fall), 1);
        check("glitch4 rise", int'(bus.rise), 0);
        check("glitch4 out", int'(bus.out), 0);
        check("glitch4 count", int'(bus.count), exp_cnt);
        bus.in2 = 1'b1;
        repeat (6) step();
        check("glitch4 held", int'(bus.out), 0);
        for (int i = 0; i < 300; i++) begin
            ev(1'b1, "sat_rise");
            ev(1'b0, "sat_fall");
        end
        check("sat final count", int'(bus.count), 255);
        check("sat final sat", int'(bus.sat), 1);
        bus.in2 = 1'b0;
        repeat (4) step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_cnt = 0;
        check("clear_edge rise", int'(bus.rise), 1);
        check("clear_edge count", int'(bus.count), 0);
        check("clear_edge sat", int'(bus.sat), 0);
        ev(1'b0, "after_clear_fall");
        ev(1'b1, "after_clear_rise");
        check("after_clear count", int'(bus.count), both ? 2 : 1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_cnt = 0;
        check("clear_only count", int'(bus.count), 0);
        for (int i = 0; i < 3; i++) begin
            ev(1'b0, "mix_fall");
            ev(1'b1, "mix_rise");
        end
        check("mix count", int'(bus.count), both ? 6 : 3);
        bus.in2 = 1'b1;
        repeat (3) step();
        #2 reset = 1'b0;
        #1 check_outs_zero("reset_pending");
        bus.in2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
        ev(1'b1, "reset_pending_rise");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
